serial_magnitude_comparator: RTL and testbench

Multi-cycle wide magnitude comparator: accepts two WIDTH-bit operands on a start strobe and resolves A<B / A>B / A=B by scanning 2-bit slices MSB-first, one slice per clock. It exits early on the first unequal slice. It sits directly downstream of the operand source. It consumes 2-bit slice-compare results internally and presents registered, one-hot result flags with a done pulse to the consuming control logic.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/serial_magnitude_comparator_if.sv | 24 ++
 rtl/cmp2_slice.sv | 13 +
 rtl/serial_magnitude_comparator.sv | 102 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// The result flags are encoded {lt, gt, eq}, so every valid result is one-hot.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_DONE
    } state_e;

    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    // Operands are scanned in 2-bit slices, so the width must be even and at least 2.
    function automatic bit width_ok(input int width);
        return (width >= 2) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle between the operand source/consumer and the comparator.
// The master drives the operands and start; the slave (the comparator) returns status and flags.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_less_b;
    logic             a_greater_b;
    logic             a_equal_b;

    modport master (
        output start, a, b,
        input  busy, done, a_less_b, a_greater_b, a_equal_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_less_b, a_greater_b, a_equal_b
    );
endinterface

// File: rtl/cmp2_slice.sv
// Purely combinational unsigned compare of one 2-bit slice.
// Exactly one of lt, gt and eq is high for any input pair.
module cmp2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       lt,
    output logic       gt,
    output logic       eq
);
    assign lt = (x < y);
    assign gt = (x > y);
    assign eq = (x == y);
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans 2-bit slices MSB-first, one per clock, and stops
// early on the first unequal slice. Busy, done and the one-hot result flags are all registered.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                         clk,
    input logic                         rst_n,
    serial_magnitude_comparator_if.slave bus
);
    localparam int NPAIR = WIDTH / 2;
    localparam int IDX_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
    end

    state_e                     state;
    logic [WIDTH-1:0]           a_q;
    logic [WIDTH-1:0]           b_q;
    logic [IDX_W-1:0]           idx;
    logic                       busy_q;
    logic                       done_q;
    logic [2:0]                 res_q;

    logic [NPAIR-1:0][1:0]      a_sl;
    logic [NPAIR-1:0][1:0]      b_sl;
    logic                       sl_lt;
    logic                       sl_gt;
    logic                       sl_eq;

    // View the latched operands as slice arrays so idx selects the slice under test.
    assign a_sl = a_q;
    assign b_sl = b_q;

    cmp2_slice u_slice (
        .x  (a_sl[idx]),
        .y  (b_sl[idx]),
        .lt (sl_lt),
        .gt (sl_gt),
        .eq (sl_eq)
    );

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values
    // and the state, index and flags update together without ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        idx    <= IDX_W'(NPAIR - 1);
                        busy_q <= 1'b1;
                        state  <= ST_COMPARE;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_COMPARE: begin
                    if (!sl_eq) begin
                        res_q  <= sl_lt ? RES_LT : RES_GT;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (idx == '0) begin
                        res_q  <= RES_EQ;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Flags are held from the last completion; a new start leaves them untouched.
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.a_less_b    = res_q[2];
    assign bus.a_greater_b = res_q[1];
    assign bus.a_equal_b   = res_q[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: directed scenarios plus randomized compares, judged against an
// arithmetic model of the expected result and of the early-exit latency.
module tb_serial_magnitude_comparator;
    localparam int WIDTH = 8;
    localparam int NPAIR = WIDTH / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.a_less_b, bus.a_greater_b, bus.a_equal_b};
    endfunction

    function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x < y) return 3'b100;
        if (x > y) return 3'b010;
        return 3'b001;
    endfunction

    // Number of compare cycles: the slice holding the highest differing bit decides.
    function automatic int model_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int bit_i = WIDTH - 1; bit_i >= 0; bit_i--)
            if (d[bit_i]) return NPAIR - bit_i / 2;
        return NPAIR;
    endfunction

    // Launch a compare at the current (negedge) time, then follow it to its done cycle.
    // inj_c > 0 drives a second start with other operands in that busy cycle.
    task automatic run(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input int inj_c, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
        int  k;
        int  busy_cnt;
        bit  seen;
        k        = model_k(av, bv);
        busy_cnt = 0;
        seen     = 1'b0;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        for (int c = 1; c <= NPAIR + 3 && !seen; c++) begin
            @(negedge clk);
            bus.start = (c == inj_c);
            if (c == inj_c) begin
                bus.a = ia;
                bus.b = ib;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                check({tag, "_latency"}, c, k + 1);
                check({tag, "_busy_cycles"}, busy_cnt, k);
                check({tag, "_busy_in_done"}, bus.busy, 1'b0);
                check({tag, "_flags"}, flags(), model_flags(av, bv));
            end
        end
        if (!seen) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_flags", flags(), 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_flags", flags(), 3'b000);

        run("equal_a5", 8'hA5, 8'hA5, 0, '0, '0);
        @(negedge clk);
        run("early_80_7f", 8'h80, 8'h7F, 0, '0, '0);
        @(negedge clk);
        run("lsb_12_13", 8'h12, 8'h13, 0, '0, '0);
        @(negedge clk);

        run("ignored_start", 8'h00, 8'h00, 2, 8'hFF, 8'h00);
        for (int i = 6; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_flags_c%0d", i), flags(), 3'b001);
            check($sformatf("hold_done_c%0d", i), bus.done, 1'b0);
        end

        run("b2b_first", 8'h80, 8'h7F, 0, '0, '0);
        run("b2b_second", 8'h01, 8'h02, 0, '0, '0);
        @(negedge clk);

        // Abort mid-compare with an asynchronous reset between clock edges.
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h13;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_flags", flags(), 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit stray;
            stray = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
            end
            check("abort_no_done", stray, 1'b0);
        end
        run("after_abort_03", 8'h03, 8'h03, 0, '0, '0);

        // Randomized compares, biased towards long common prefixes to exercise late exits.
        for (int t = 0; t < 60; t++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [WIDTH-1:0] m;
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                default: begin
                    m  = WIDTH'($urandom_range(1, 3));
                    m  = m << (2 * $urandom_range(0, NPAIR - 1));
                    rb = ra ^ m;
                end
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run($sformatf("rand%0d", t), ra, rb, 0, '0, '0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
